// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the router packet generator
//
// Purpose: state enum, field widths, header packing and LFSR tap mask shared
//          by router_pkt_gen and router_lfsr8.
// Ports:   none (package).
package router_pkg;

    localparam int ADDR_W = 2;
    localparam int LEN_W  = 6;
    localparam int DATA_W = 8;

    // Feedback taps at bits 7,5,4,3.
    localparam logic [DATA_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        PG_IDLE,
        PG_HEADER,
        PG_PAYLOAD,
        PG_PARITY,
        PG_DONE
    } pg_state_t;

    function automatic logic [DATA_W-1:0] pack_header(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_lfsr8.sv
// rtl/router_lfsr8.sv - 8-bit Fibonacci LFSR with load and advance enable
//
// Purpose: payload byte source for the packet generator.
// Ports:   clk, rst     - clock, asynchronous active-high reset
//          i_load       - load i_seed (has priority over i_adv)
//          i_seed       - value to load
//          i_adv        - advance one step
//          o_state      - current LFSR value
//          o_next       - value after one advance (for look-ahead presentation)
module router_lfsr8
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_seed,
    input  logic              i_adv,
    output logic [DATA_W-1:0] o_state,
    output logic [DATA_W-1:0] o_next
);

    logic [DATA_W-1:0] r_state;
    logic              w_fb;

    assign w_fb    = ^(r_state & LFSR_TAPS);
    assign o_next  = {r_state[DATA_W-2:0], w_fb};
    assign o_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_adv) begin
            r_state <= o_next;
        end
    end

endmodule

// File: rtl/router_pkt_gen.sv
// rtl/router_pkt_gen.sv - packet source for the 1x3 router input port
//
// Purpose: emits header {len,addr}, len LFSR payload bytes, then an even
//          parity byte (optionally inverted); honours router busy.
// Ports:   clk, rst                     - clock, asynchronous active-high reset
//          start, dest_addr, payload_len,
//          seed, inj_err                - packet request (sampled in IDLE)
//          busy                         - router busy, holds current byte
//          data_out, pkt_valid          - to router data_in / pkt_valid
//          gen_busy, done, pkt_cnt      - status
module router_pkt_gen
    import router_pkg::*;
#(
    parameter int                CNT_W         = 16,
    parameter logic [DATA_W-1:0] LFSR_SEED_DEF = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  payload_len,
    input  logic [DATA_W-1:0] seed,
    input  logic              inj_err,
    input  logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              pkt_valid,
    output logic              gen_busy,
    output logic              done,
    output logic [CNT_W-1:0]  pkt_cnt
);

    pg_state_t         r_state, w_state_nxt;
    logic [LEN_W-1:0]  r_len,   w_len_nxt;
    logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
    logic              r_inj,   w_inj_nxt;
    logic [LEN_W:0]    r_cnt,   w_cnt_nxt;   // one extra bit so len=63 cannot wrap
    logic [DATA_W-1:0] r_par,   w_par_nxt;
    logic [DATA_W-1:0] r_data,  w_data_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_gbusy, w_gbusy_nxt;
    logic              r_done,  w_done_nxt;
    logic [CNT_W-1:0]  r_pcnt,  w_pcnt_nxt;

    logic              w_load, w_adv;
    logic [DATA_W-1:0] w_seed, w_lfsr, w_lfsr_next, w_par_fin;

    // A zero seed would lock the LFSR at zero.
    assign w_seed    = (seed == '0) ? LFSR_SEED_DEF : seed;
    // Accumulator including the byte being consumed this edge.
    assign w_par_fin = r_par ^ r_data;

    router_lfsr8 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_seed  (w_seed),
        .i_adv   (w_adv),
        .o_state (w_lfsr),
        .o_next  (w_lfsr_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PG_IDLE;
            r_len   <= '0;
            r_addr  <= '0;
            r_inj   <= 1'b0;
            r_cnt   <= '0;
            r_par   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_gbusy <= 1'b0;
            r_done  <= 1'b0;
            r_pcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_addr  <= w_addr_nxt;
            r_inj   <= w_inj_nxt;
            r_cnt   <= w_cnt_nxt;
            r_par   <= w_par_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_gbusy <= w_gbusy_nxt;
            r_done  <= w_done_nxt;
            r_pcnt  <= w_pcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_addr_nxt  = r_addr;
        w_inj_nxt   = r_inj;
        w_cnt_nxt   = r_cnt;
        w_par_nxt   = r_par;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_gbusy_nxt = r_gbusy;
        w_done_nxt  = r_done;
        w_pcnt_nxt  = r_pcnt;
        w_load      = 1'b0;
        w_adv       = 1'b0;

        case (r_state)
            PG_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_len_nxt   = payload_len;
                    w_addr_nxt  = dest_addr;
                    w_inj_nxt   = inj_err;
                    w_cnt_nxt   = '0;
                    w_data_nxt  = pack_header(payload_len, dest_addr);
                    w_par_nxt   = pack_header(payload_len, dest_addr);
                    w_valid_nxt = 1'b1;
                    w_gbusy_nxt = 1'b1;
                    w_state_nxt = PG_HEADER;
                end
            end
            PG_HEADER: begin
                if (!busy) begin
                    if (r_len == '0) begin
                        // No payload: the accumulator already holds the header.
                        w_data_nxt  = r_par ^ {DATA_W{r_inj}};
                        w_valid_nxt = 1'b0;
                        w_state_nxt = PG_PARITY;
                    end else begin
                        w_data_nxt  = w_lfsr;
                        w_cnt_nxt   = 7'd1;
                        w_state_nxt = PG_PAYLOAD;
                    end
                end
            end
            PG_PAYLOAD: begin
                if (!busy) begin
                    w_par_nxt = w_par_fin;
                    if (r_cnt < {1'b0, r_len}) begin
                        w_adv      = 1'b1;
                        w_data_nxt = w_lfsr_next;
                        w_cnt_nxt  = r_cnt + 7'd1;
                    end else begin
                        w_data_nxt  = w_par_fin ^ {DATA_W{r_inj}};
                        w_valid_nxt = 1'b0;
                        w_state_nxt = PG_PARITY;
                    end
                end
            end
            PG_PARITY: begin
                if (!busy) begin
                    w_data_nxt  = '0;
                    w_valid_nxt = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pcnt_nxt  = r_pcnt + CNT_W'(1);
                    w_state_nxt = PG_DONE;
                end
            end
            PG_DONE: begin
                w_done_nxt  = 1'b0;
                w_gbusy_nxt = 1'b0;
                w_state_nxt = PG_IDLE;
            end
            default: w_state_nxt = PG_IDLE;
        endcase
    end

    assign data_out  = r_data;
    assign pkt_valid = r_valid;
    assign gen_busy  = r_gbusy;
    assign done      = r_done;
    assign pkt_cnt   = r_pcnt;

endmodule

// File: tb/tb_router_pkt_gen.sv
// tb/tb_router_pkt_gen.sv - self-checking bench for router_pkt_gen
module tb_router_pkt_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  dest_addr;
    logic [5:0]  payload_len;
    logic [7:0]  seed;
    logic        inj_err;
    logic        busy;
    logic [7:0]  data_out;
    logic        pkt_valid;
    logic        gen_busy;
    logic        done;
    logic [15:0] pkt_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [8:0]  exp_q[$];      // {pkt_valid, data_out}
    logic [15:0] exp_cnt = '0;
    logic        done_seen[15];

    always #5 clk = ~clk;

    router_pkt_gen #(.CNT_W(16), .LFSR_SEED_DEF(8'hFF)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dest_addr   (dest_addr),
        .payload_len (payload_len),
        .seed        (seed),
        .inj_err     (inj_err),
        .busy        (busy),
        .data_out    (data_out),
        .pkt_valid   (pkt_valid),
        .gen_busy    (gen_busy),
        .done        (done),
        .pkt_cnt     (pkt_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic push_pkt(input logic [5:0] len, input logic [1:0] addr,
                            input logic [7:0] sd, input logic inj);
        logic [7:0] hdr;
        logic [7:0] acc;
        logic [7:0] s;
        hdr = {len, addr};
        acc = hdr;
        s   = (sd == 8'h00) ? 8'hFF : sd;
        exp_q.push_back({1'b1, hdr});
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back({1'b1, s});
            acc = acc ^ s;
            s   = lfsr_step(s);
        end
        exp_q.push_back({1'b0, inj ? ~acc : acc});
    endtask

    // Called at a negedge; returns at a negedge with the generator idle.
    task automatic send_pkt(input string name, input logic [5:0] len, input logic [1:0] addr,
                            input logic [7:0] sd, input logic inj,
                            input int busy_at, input int busy_n);
        logic [8:0] e;
        int idx;
        idx = 0;
        push_pkt(len, addr, sd, inj);
        payload_len = len;
        dest_addr   = addr;
        seed        = sd;
        inj_err     = inj;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({name, "_data"},  32'(data_out),  32'(e[7:0]));
            chk({name, "_valid"}, 32'(pkt_valid), 32'(e[8]));
            chk({name, "_gbusy"}, 32'(gen_busy),  32'(1));
            if (idx == busy_at) begin
                busy = 1'b1;
                for (int k = 0; k < busy_n; k++) begin
                    @(negedge clk);
                    chk({name, "_hold_data"},  32'(data_out),  32'(e[7:0]));
                    chk({name, "_hold_valid"}, 32'(pkt_valid), 32'(e[8]));
                    chk({name, "_hold_done"},  32'(done),      32'(0));
                end
                busy = 1'b0;
            end
            @(negedge clk);
            idx++;
        end
        exp_cnt = exp_cnt + 16'd1;
        chk({name, "_done"},      32'(done),      32'(1));
        chk({name, "_pkt_cnt"},   32'(pkt_cnt),   32'(exp_cnt));
        chk({name, "_end_data"},  32'(data_out),  32'(0));
        chk({name, "_end_valid"}, 32'(pkt_valid), 32'(0));
        @(negedge clk);
        chk({name, "_done_clr"},  32'(done),      32'(0));
        chk({name, "_gbusy_clr"}, 32'(gen_busy),  32'(0));
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        dest_addr   = '0;
        payload_len = '0;
        seed        = '0;
        inj_err     = 1'b0;
        busy        = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data",    32'(data_out),  32'(0));
        chk("rst_valid",   32'(pkt_valid), 32'(0));
        chk("rst_gbusy",   32'(gen_busy),  32'(0));
        chk("rst_done",    32'(done),      32'(0));
        chk("rst_pkt_cnt", 32'(pkt_cnt),   32'(0));
        rst = 1'b0;
        @(negedge clk);

        send_pkt("len14",  6'd14, 2'd0, 8'h01, 1'b0, -1, 0);
        send_pkt("busy12", 6'd12, 2'd1, 8'h37, 1'b0,  5, 3);
        send_pkt("inj16",  6'd16, 2'd2, 8'hA5, 1'b1, -1, 0);
        send_pkt("len0",   6'd0,  2'd0, 8'h00, 1'b0, -1, 0);
        send_pkt("len63",  6'd63, 2'd3, 8'h80, 1'b0, 20, 2);

        // Asynchronous reset in the middle of a payload.
        payload_len = 6'd19;
        dest_addr   = 2'd1;
        seed        = 8'h5A;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_valid", 32'(pkt_valid), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("arst_data",    32'(data_out),  32'(0));
        chk("arst_valid",   32'(pkt_valid), 32'(0));
        chk("arst_gbusy",   32'(gen_busy),  32'(0));
        chk("arst_pkt_cnt", 32'(pkt_cnt),   32'(0));
        exp_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_pkt("post_rst", 6'd3, 2'd2, 8'h11, 1'b0, -1, 0);

        // start held high: one len=1 packet every 5 cycles.
        payload_len = 6'd1;
        dest_addr   = 2'd0;
        seed        = 8'h01;
        inj_err     = 1'b0;
        start       = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            done_seen[i] = done;
        end
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("cont_done_%0d", i), 32'(done_seen[i]), 32'((i % 5) == 3));
        end
        exp_cnt = exp_cnt + 16'd3;
        chk("cont_pkt_cnt", 32'(pkt_cnt),  32'(exp_cnt));
        chk("cont_idle",    32'(gen_busy), 32'(0));
        repeat (2) @(negedge clk);
        chk("cont_no_extra", 32'(gen_busy), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
